gps_srq_snap: RTL and testbench

Parametrised successor to the GPS service-request and clock-replica snapshot logic. It tracks per-channel epoch requests, masks them, and counts missed (overrun) epochs per channel with saturation. It serialises either the SRQ word or a {ticks, pending, overrun} snapshot MSB-first to the host CPU, and offers a registered priority-encoded "next channel to service" output. It sits between the DEMOD array and the CPU serial-read path in the GPS top.

---
 rtl/gps_srq_snap_pkg.sv | 20 ++
 rtl/gps_srq_snap_if.sv | 35 +++
 rtl/gps_prio_enc.sv | 26 ++
 rtl/gps_srq_snap.sv | 127 ++++++++++++
 tb/tb_gps_srq_snap.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gps_srq_snap_pkg.sv
// Shared constants for the GPS SRQ/snapshot slice: channel geometry,
// stream select encodings and the snapshot width formula.
package gps_srq_snap_pkg;

   localparam int unsigned GPS_CHANS     = 12;
   localparam int unsigned GPS_CW        = 4;
   localparam int unsigned GPS_TICK_BITS = 48;
   localparam int unsigned GPS_OVR_BITS  = 2;

   localparam logic SEL_SRQ  = 1'b0;
   localparam logic SEL_SNAP = 1'b1;

   // Snapshot layout: {ticks, pending, ovr[NCHAN-1] .. ovr[0]}
   function automatic int unsigned snap_w(input int unsigned tick_bits,
                                          input int unsigned nchan,
                                          input int unsigned ovr_bits);
      return tick_bits + nchan + nchan * ovr_bits;
   endfunction

endpackage

// File: rtl/gps_srq_snap_if.sv
// Host/demod-side signal bundle of gps_srq_snap; master drives the
// requests and strobes, slave is the snapshot block itself.
interface gps_srq_snap_if #(
   parameter int unsigned NCHAN     = gps_srq_snap_pkg::GPS_CHANS,
   parameter int unsigned CW        = gps_srq_snap_pkg::GPS_CW,
   parameter int unsigned TICK_BITS = gps_srq_snap_pkg::GPS_TICK_BITS
) ();

   logic [NCHAN-1:0]     chan_srq;
   logic                 host_srq;
   logic [TICK_BITS-1:0] ticks;
   logic                 mask_wr;
   logic [NCHAN-1:0]     mask_din;
   logic                 ack_valid;
   logic [CW-1:0]        ack_chan;
   logic                 load_srq;
   logic                 load_snap;
   logic                 shift;
   logic                 ser;
   logic                 next_valid;
   logic [CW-1:0]        next_chan;

   modport master (
      output chan_srq, host_srq, ticks, mask_wr, mask_din,
             ack_valid, ack_chan, load_srq, load_snap, shift,
      input  ser, next_valid, next_chan
   );

   modport slave (
      input  chan_srq, host_srq, ticks, mask_wr, mask_din,
             ack_valid, ack_chan, load_srq, load_snap, shift,
      output ser, next_valid, next_chan
   );

endinterface

// File: rtl/gps_prio_enc.sv
// LSB-first priority encoder: reports the lowest set request bit.
// Index is forced to 0 when nothing is requested.
module gps_prio_enc
   import gps_srq_snap_pkg::*;
#(
   parameter int unsigned NCHAN = GPS_CHANS,
   parameter int unsigned CW    = GPS_CW
) (
   input  logic [NCHAN-1:0] req,
   output logic             valid_c,
   output logic [CW-1:0]    idx_c
);

   // Walk downward so the lowest set bit is the last one written.
   always_comb begin
      valid_c = 1'b0;
      idx_c   = '0;
      for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid_c = 1'b1;
            idx_c   = CW'(i);
         end
      end
   end

endmodule

// File: rtl/gps_srq_snap.sv
// GPS service-request tracker with per-channel overrun counting, SRQ and
// tick/pending/overrun snapshot serialisers, and a next-channel hint.
module gps_srq_snap
   import gps_srq_snap_pkg::*;
#(
   parameter int unsigned NCHAN     = GPS_CHANS,
   parameter int unsigned CW        = GPS_CW,
   parameter int unsigned TICK_BITS = GPS_TICK_BITS,
   parameter int unsigned OVR_BITS  = GPS_OVR_BITS
) (
   input logic           clk,
   input logic           rst,
   gps_srq_snap_if.slave bus
);

   localparam int unsigned SRQ_W  = NCHAN + 1;
   localparam int unsigned SNAP_W = snap_w(TICK_BITS, NCHAN, OVR_BITS);
   localparam logic [OVR_BITS-1:0] OVR_MAX = '1;

   logic [NCHAN-1:0]          pending;
   logic [NCHAN*OVR_BITS-1:0] ovr_flat;
   logic [NCHAN-1:0]          mask;
   logic                      host_noted;
   logic [SRQ_W-1:0]          srq_sh;
   logic [SNAP_W-1:0]         snap_sh;
   logic                      sel;
   logic [NCHAN-1:0]          req_masked;
   logic                      enc_valid;
   logic [CW-1:0]             enc_idx;
   logic                      any_load;

   // Per-channel pending flag and saturating overrun counter.
   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      logic                clr;
      logic                pend_q;
      logic [OVR_BITS-1:0] ovr_q;

      assign clr = bus.ack_valid && (bus.ack_chan == CW'(i));

      always_ff @(posedge clk) begin
         if (rst) begin
            pend_q <= 1'b0;
            ovr_q  <= '0;
         end else begin
            pend_q <= bus.chan_srq[i] | (pend_q & ~clr);
            if (clr) begin
               ovr_q <= '0;
            end else if (bus.chan_srq[i] && pend_q && (ovr_q != OVR_MAX)) begin
               ovr_q <= ovr_q + OVR_BITS'(1);
            end
         end
      end

      assign pending[i]                          = pend_q;
      assign ovr_flat[i*OVR_BITS +: OVR_BITS]    = ovr_q;
   end

   // Mask register and sticky host request, re-armed by each SRQ capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask       <= '0;
         host_noted <= 1'b0;
      end else begin
         if (bus.mask_wr) begin
            mask <= bus.mask_din;
         end
         if (bus.load_srq) begin
            host_noted <= bus.host_srq;
         end else begin
            host_noted <= host_noted | bus.host_srq;
         end
      end
   end

   assign any_load = bus.load_srq | bus.load_snap;

   // Loads beat shifts; only the selected shifter advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         srq_sh  <= '0;
         snap_sh <= '0;
         sel     <= SEL_SRQ;
      end else begin
         if (bus.load_srq) begin
            srq_sh <= {host_noted | bus.host_srq, pending & mask};
         end else if (bus.shift && !any_load && (sel == SEL_SRQ)) begin
            srq_sh <= srq_sh << 1;
         end

         if (bus.load_snap) begin
            snap_sh <= {bus.ticks, pending, ovr_flat};
         end else if (bus.shift && !any_load && (sel == SEL_SNAP)) begin
            snap_sh <= snap_sh << 1;
         end

         if (bus.load_snap) begin
            sel <= SEL_SNAP;
         end else if (bus.load_srq) begin
            sel <= SEL_SRQ;
         end
      end
   end

   assign bus.ser = (sel == SEL_SNAP) ? snap_sh[SNAP_W-1] : srq_sh[SRQ_W-1];

   assign req_masked = pending & mask;

   gps_prio_enc #(
      .NCHAN (NCHAN),
      .CW    (CW)
   ) u_prio (
      .req     (req_masked),
      .valid_c (enc_valid),
      .idx_c   (enc_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.next_valid <= 1'b0;
         bus.next_chan  <= '0;
      end else begin
         bus.next_valid <= enc_valid;
         bus.next_chan  <= enc_idx;
      end
   end

endmodule

// File: tb/tb_gps_srq_snap.sv
// Bench for gps_srq_snap: table-driven next-channel vectors plus serial
// stream scoreboard for SRQ and snapshot captures.
module tb_gps_srq_snap;
   import gps_srq_snap_pkg::*;

   localparam int unsigned NCHAN  = 12;
   localparam int unsigned CW     = 4;
   localparam int unsigned TB_TB  = 48;
   localparam int unsigned OB     = 2;
   localparam int unsigned SRQ_W  = 13;
   localparam int unsigned SNAP_W = 84;
   localparam logic [47:0] TICKS_VAL = 48'h0123_4567_89AB;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gps_srq_snap_if #(.NCHAN(NCHAN), .CW(CW), .TICK_BITS(TB_TB)) bus ();

   gps_srq_snap #(
      .NCHAN(NCHAN), .CW(CW), .TICK_BITS(TB_TB), .OVR_BITS(OB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      string       name;
      int unsigned len;
      logic [127:0] bits;
   } stream_t;

   typedef struct {
      logic [11:0] srq;
      logic        ack_v;
      logic [3:0]  ack_c;
      logic        exp_v;
      logic [3:0]  exp_c;
   } vec_t;

   stream_t sb_q[$];
   vec_t    vt[8];
   int      errors = 0;
   int      checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_srq(input logic [11:0] v);
      bus.chan_srq = v;
      cyc();
      bus.chan_srq = '0;
   endtask

   task automatic ack(input logic [3:0] c);
      bus.ack_valid = 1'b1;
      bus.ack_chan  = c;
      cyc();
      bus.ack_valid = 1'b0;
      bus.ack_chan  = '0;
   endtask

   task automatic check_next(input string name, input logic v, input logic [3:0] c);
      check({name, " next_valid"}, 128'(bus.next_valid), 128'(v));
      check({name, " next_chan"},  128'(bus.next_chan),  128'(c));
   endtask

   function automatic logic [23:0] ovr_field(input int ch, input int val);
      return 24'(val) << (2 * ch);
   endfunction

   function automatic logic [127:0] snap_word(input logic [11:0] pend, input logic [23:0] ovrf);
      return 128'({TICKS_VAL, pend, ovrf});
   endfunction

   // Strobe loads and queue the stream the DUT must then produce.
   task automatic load_expect(input logic srq, input logic snap, input logic with_shift,
                              input string name, input int unsigned len, input logic [127:0] exp);
      stream_t e;
      e.name = name;
      e.len  = len;
      e.bits = exp;
      sb_q.push_back(e);
      bus.load_srq  = srq;
      bus.load_snap = snap;
      bus.shift     = with_shift;
      cyc();
      bus.load_srq  = 1'b0;
      bus.load_snap = 1'b0;
      bus.shift     = 1'b0;
   endtask

   // Shift out the oldest queued stream MSB-first and compare, then its tail.
   task automatic drain();
      stream_t      e;
      logic [127:0] got;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL drain: no expected stream queued");
         return;
      end
      e   = sb_q.pop_front();
      got = '0;
      for (int b = int'(e.len) - 1; b >= 0; b--) begin
         got[b]    = bus.ser;
         bus.shift = 1'b1;
         cyc();
         bus.shift = 1'b0;
      end
      check({e.name, " stream"}, got, e.bits);
      check({e.name, " tail"}, 128'(bus.ser), 128'(0));
   endtask

   initial begin
      logic       pv;
      logic [3:0] pc;

      rst = 1'b1;
      bus.chan_srq = '0; bus.host_srq = 1'b0; bus.ticks = TICKS_VAL;
      bus.mask_wr = 1'b0; bus.mask_din = '0; bus.ack_valid = 1'b0; bus.ack_chan = '0;
      bus.load_srq = 1'b0; bus.load_snap = 1'b0; bus.shift = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;

      check("reset ser", 128'(bus.ser), 128'(0));
      check_next("reset", 1'b0, 4'd0);

      // Next-channel vectors: {chan_srq, ack_valid, ack_chan, exp_valid, exp_chan}
      vt[0] = '{12'h024, 1'b0, 4'd0,  1'b1, 4'd2};
      vt[1] = '{12'h000, 1'b1, 4'd2,  1'b1, 4'd5};
      vt[2] = '{12'h000, 1'b1, 4'd5,  1'b0, 4'd0};
      vt[3] = '{12'h800, 1'b0, 4'd0,  1'b1, 4'd11};
      vt[4] = '{12'h000, 1'b1, 4'd12, 1'b1, 4'd11};
      vt[5] = '{12'h000, 1'b1, 4'd15, 1'b1, 4'd11};
      vt[6] = '{12'h001, 1'b1, 4'd11, 1'b1, 4'd0};
      vt[7] = '{12'h000, 1'b1, 4'd0,  1'b0, 4'd0};

      bus.mask_wr = 1'b1; bus.mask_din = 12'hFFF;
      cyc();
      bus.mask_wr = 1'b0;

      pv = 1'b0; pc = 4'd0;
      for (int k = 0; k < 8; k++) begin
         bus.chan_srq  = vt[k].srq;
         bus.ack_valid = vt[k].ack_v;
         bus.ack_chan  = vt[k].ack_c;
         cyc();
         bus.chan_srq = '0; bus.ack_valid = 1'b0; bus.ack_chan = '0;
         check_next($sformatf("vec%0d latency", k), pv, pc);
         cyc();
         check_next($sformatf("vec%0d", k), vt[k].exp_v, vt[k].exp_c);
         pv = vt[k].exp_v;
         pc = vt[k].exp_c;
      end

      // Overrun counter saturation on channel 3.
      pulse_srq(12'h008);
      for (int k = 0; k < 4; k++) begin
         pulse_srq(12'h008);
         load_expect(1'b0, 1'b1, 1'b0, $sformatf("ovr3 step%0d", k), SNAP_W,
                     snap_word(12'h008, ovr_field(3, (k + 1 > 3) ? 3 : k + 1)));
         drain();
      end
      ack(4'd3);
      load_expect(1'b0, 1'b1, 1'b0, "ovr3 acked", SNAP_W, snap_word(12'h000, 24'h0));
      drain();

      // Same-cycle set and ack on channel 7.
      pulse_srq(12'h080);
      pulse_srq(12'h080);
      load_expect(1'b0, 1'b1, 1'b0, "ch7 ovr1", SNAP_W, snap_word(12'h080, ovr_field(7, 1)));
      drain();
      bus.chan_srq = 12'h080; bus.ack_valid = 1'b1; bus.ack_chan = 4'd7;
      cyc();
      bus.chan_srq = '0; bus.ack_valid = 1'b0; bus.ack_chan = '0;
      load_expect(1'b0, 1'b1, 1'b0, "ch7 set+ack", SNAP_W, snap_word(12'h080, 24'h0));
      drain();
      check_next("ch7 pending", 1'b1, 4'd7);
      ack(4'd7);

      // SRQ word with mask and sticky host request.
      bus.host_srq = 1'b1;
      cyc();
      bus.host_srq = 1'b0;
      bus.mask_wr = 1'b1; bus.mask_din = 12'h00F;
      pulse_srq(12'h0A5);
      bus.mask_wr = 1'b0;
      cyc();
      check_next("masked a5", 1'b1, 4'd0);
      load_expect(1'b1, 1'b0, 1'b0, "srq host", SRQ_W, 128'(13'h1005));
      drain();
      load_expect(1'b1, 1'b0, 1'b0, "srq host cleared", SRQ_W, 128'(13'h0005));
      drain();
      ack(4'd0);
      cyc();
      check_next("masked after ack0", 1'b1, 4'd2);
      ack(4'd2);
      cyc();
      check_next("only masked left", 1'b0, 4'd0);
      ack(4'd5);
      ack(4'd7);

      // Snapshot with live ticks, then switch back to a clean SRQ stream.
      pulse_srq(12'h001);
      pulse_srq(12'h001);
      pulse_srq(12'h001);
      load_expect(1'b0, 1'b1, 1'b0, "snap ch0", SNAP_W, snap_word(12'h001, ovr_field(0, 2)));
      drain();
      load_expect(1'b1, 1'b0, 1'b0, "srq after snap", SRQ_W, 128'(13'h0001));
      drain();

      // Both loads with a shift: snapshot selected, nothing shifted.
      load_expect(1'b1, 1'b1, 1'b1, "dual load", SNAP_W, snap_word(12'h001, ovr_field(0, 2)));
      drain();

      // Reset in the middle of a shift-out.
      bus.load_srq = 1'b1;
      cyc();
      bus.load_srq = 1'b0;
      bus.shift = 1'b1;
      repeat (3) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.shift = 1'b0;
      check("post-reset ser", 128'(bus.ser), 128'(0));
      check_next("post-reset", 1'b0, 4'd0);
      load_expect(1'b0, 1'b1, 1'b0, "post-reset snap", SNAP_W, snap_word(12'h000, 24'h0));
      drain();
      pulse_srq(12'h002);
      cyc();
      check_next("post-reset mask cleared", 1'b0, 4'd0);
      load_expect(1'b1, 1'b0, 1'b0, "post-reset srq", SRQ_W, 128'(13'h0000));
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
